// File: rtl/peak_clint_pkg.sv
// Register offsets, register select and byte-lane merge shared by the CLINT top.
package peak_clint_pkg;

    localparam logic [15:0] CLINT_MSIP        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

    typedef enum logic [2:0] {
        REG_NONE        = 3'd0,
        REG_MSIP        = 3'd1,
        REG_MTIMECMP_LO = 3'd2,
        REG_MTIMECMP_HI = 3'd3,
        REG_MTIME_LO    = 3'd4,
        REG_MTIME_HI    = 3'd5
    } clint_reg_e;

    function automatic clint_reg_e clint_decode(input logic [15:0] offset);
        clint_reg_e sel;
        case ({offset[15:2], 2'b00})
            CLINT_MSIP:        sel = REG_MSIP;
            CLINT_MTIMECMP_LO: sel = REG_MTIMECMP_LO;
            CLINT_MTIMECMP_HI: sel = REG_MTIMECMP_HI;
            CLINT_MTIME_LO:    sel = REG_MTIME_LO;
            CLINT_MTIME_HI:    sel = REG_MTIME_HI;
            default:           sel = REG_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] clint_merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] wdata,
        input logic [3:0]  wstrb
    );
        logic [31:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : old_val[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/peak_clint_tick_gen.sv
// mtime prescaler: emits one tick every TICK_DIV enabled cycles; holds its count while disabled.
module peak_clint_tick_gen #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [15:0] LAST_CNT = 16'(TICK_DIV - 32'd1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next prescaler count and tick strobe.
    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (en_i) begin
            if (cnt_q >= LAST_CNT) begin
                cnt_d  = 16'd0;
                tick_o = 1'b1;
            end else begin
                cnt_d  = cnt_q + 16'd1;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Prescaler count register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/peak_rv32i_clint.sv
// Core-local interruptor: mtime/mtimecmp/msip registers, single-cycle bus slave,
// timer compare and software-interrupt pulse for the CSR block.
module peak_rv32i_clint
    import peak_clint_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 1,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        BUS_EN,
    input  logic        BUS_WE,
    input  logic [15:0] BUS_ADDR,
    input  logic [3:0]  BUS_WSTRB,
    input  logic [31:0] BUS_WDATA,
    output logic [31:0] BUS_RDATA,
    output logic        BUS_READY,
    output logic        BUS_ERR,
    input  logic        DEBUG_HALT,
    output logic        TIMER_EXPIRED,
    output logic        SW_INTERRUPT,
    output logic        MSIP,
    output logic [63:0] MTIME
);

    logic        tick_s;
    logic [15:0] offset_s;
    clint_reg_e  sel_s;
    logic        wr_s;
    logic        rd_s;

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q;
    logic        err_q;
    logic        sw_irq_q;
    logic        expired_q;

    peak_clint_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .en_i   (!DEBUG_HALT),
        .tick_o (tick_s)
    );

    assign offset_s = BUS_ADDR - BASE_ADDR;
    assign sel_s    = clint_decode(offset_s);
    assign wr_s     = BUS_EN & BUS_WE;
    assign rd_s     = BUS_EN & ~BUS_WE;

    // Register next-state from tick and bus write; read data mux.
    always_comb begin
        if (tick_s) begin
            mtime_d = mtime_q + 64'd1;
        end else begin
            mtime_d = mtime_q;
        end
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        rdata_d    = 32'd0;
        if (wr_s) begin
            case (sel_s)
                REG_MSIP: begin
                    if (BUS_WSTRB[0]) begin
                        msip_d = BUS_WDATA[0];
                    end else begin
                        msip_d = msip_q;
                    end
                end
                REG_MTIMECMP_LO: mtimecmp_d[31:0]  = clint_merge_bytes(mtimecmp_q[31:0], BUS_WDATA, BUS_WSTRB);
                REG_MTIMECMP_HI: mtimecmp_d[63:32] = clint_merge_bytes(mtimecmp_q[63:32], BUS_WDATA, BUS_WSTRB);
                // A write to either mtime half replaces the whole update: a coincident tick is dropped.
                REG_MTIME_LO: mtime_d = {mtime_q[63:32], clint_merge_bytes(mtime_q[31:0], BUS_WDATA, BUS_WSTRB)};
                REG_MTIME_HI: mtime_d = {clint_merge_bytes(mtime_q[63:32], BUS_WDATA, BUS_WSTRB), mtime_q[31:0]};
                default: begin
                end
            endcase
        end else if (rd_s) begin
            case (sel_s)
                REG_MSIP:        rdata_d = {31'd0, msip_q};
                REG_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
                REG_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
                REG_MTIME_LO:    rdata_d = mtime_q[31:0];
                REG_MTIME_HI:    rdata_d = mtime_q[63:32];
                default:         rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = 32'd0;
        end
    end

    // State and registered bus/interrupt outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_q     <= 1'b0;
            rdata_q    <= 32'd0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            sw_irq_q   <= 1'b0;
            expired_q  <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            rdata_q    <= rdata_d;
            ready_q    <= BUS_EN;
            err_q      <= BUS_EN & (sel_s == REG_NONE);
            sw_irq_q   <= msip_d & ~msip_q;
            expired_q  <= (mtime_q >= mtimecmp_q);
        end
    end

    assign BUS_RDATA     = rdata_q;
    assign BUS_READY     = ready_q;
    assign BUS_ERR       = err_q;
    assign TIMER_EXPIRED = expired_q;
    assign SW_INTERRUPT  = sw_irq_q;
    assign MSIP          = msip_q;
    assign MTIME         = mtime_q;

endmodule

// File: tb/tb_peak_rv32i_clint.sv
// Bench for peak_rv32i_clint: two instances (TICK_DIV 4 and 1) on one bus, checked against an arithmetic model.
module tb_peak_rv32i_clint;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        BUS_EN = 1'b0;
    logic        BUS_WE = 1'b0;
    logic [15:0] BUS_ADDR = 16'h0000;
    logic [3:0]  BUS_WSTRB = 4'h0;
    logic [31:0] BUS_WDATA = 32'h0;
    logic        DEBUG_HALT = 1'b0;

    logic [31:0] rdata   [2];
    logic        ready   [2];
    logic        err     [2];
    logic        expired [2];
    logic        swi     [2];
    logic        msip_o  [2];
    logic [63:0] mtime   [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    peak_rv32i_clint #(.TICK_DIV(4), .BASE_ADDR(16'h0000)) dut4 (
        .CLK(CLK), .RST_N(RST_N), .BUS_EN(BUS_EN), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR),
        .BUS_WSTRB(BUS_WSTRB), .BUS_WDATA(BUS_WDATA), .BUS_RDATA(rdata[0]), .BUS_READY(ready[0]),
        .BUS_ERR(err[0]), .DEBUG_HALT(DEBUG_HALT), .TIMER_EXPIRED(expired[0]),
        .SW_INTERRUPT(swi[0]), .MSIP(msip_o[0]), .MTIME(mtime[0]));

    peak_rv32i_clint #(.TICK_DIV(1), .BASE_ADDR(16'h0000)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .BUS_EN(BUS_EN), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR),
        .BUS_WSTRB(BUS_WSTRB), .BUS_WDATA(BUS_WDATA), .BUS_RDATA(rdata[1]), .BUS_READY(ready[1]),
        .BUS_ERR(err[1]), .DEBUG_HALT(DEBUG_HALT), .TIMER_EXPIRED(expired[1]),
        .SW_INTERRUPT(swi[1]), .MSIP(msip_o[1]), .MTIME(mtime[1]));

    // ---------------- reference model ----------------
    logic [63:0] m_time [2];
    int          m_pre  [2];
    logic        m_exp  [2];
    logic [63:0] m_cmp;
    logic        m_msip;
    logic        m_sw;

    function automatic int tb_div(int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic logic [31:0] tb_merge(logic [31:0] old_v, logic [31:0] new_v, logic [3:0] strb);
        logic [31:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    function automatic bit tb_mapped(logic [15:0] a);
        logic [15:0] w;
        w = a & 16'hFFFC;
        return (w == 16'h0000) || (w == 16'h4000) || (w == 16'h4004) ||
               (w == 16'hBFF8) || (w == 16'hBFFC);
    endfunction

    function automatic logic [31:0] tb_read(int i, logic [15:0] a);
        case (a & 16'hFFFC)
            16'h0000: return {31'd0, m_msip};
            16'h4000: return m_cmp[31:0];
            16'h4004: return m_cmp[63:32];
            16'hBFF8: return m_time[i][31:0];
            16'hBFFC: return m_time[i][63:32];
            default:  return 32'd0;
        endcase
    endfunction

    always @(posedge CLK) begin
        logic        wr;
        logic [15:0] a;
        wr = BUS_EN && BUS_WE;
        a  = BUS_ADDR & 16'hFFFC;
        if (!RST_N) begin
            for (int i = 0; i < 2; i++) begin
                m_time[i] <= 64'd0;
                m_pre[i]  <= 0;
                m_exp[i]  <= 1'b0;
            end
            m_cmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
            m_msip <= 1'b0;
            m_sw   <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_exp[i] <= (m_time[i] >= m_cmp);
                if (!DEBUG_HALT) m_pre[i] <= (m_pre[i] + 1) % tb_div(i);
                if (wr && a == 16'hBFF8)
                    m_time[i] <= {m_time[i][63:32], tb_merge(m_time[i][31:0], BUS_WDATA, BUS_WSTRB)};
                else if (wr && a == 16'hBFFC)
                    m_time[i] <= {tb_merge(m_time[i][63:32], BUS_WDATA, BUS_WSTRB), m_time[i][31:0]};
                else if (!DEBUG_HALT && (m_pre[i] + 1 == tb_div(i)))
                    m_time[i] <= m_time[i] + 64'd1;
            end
            if (wr && a == 16'h4000) m_cmp[31:0]  <= tb_merge(m_cmp[31:0], BUS_WDATA, BUS_WSTRB);
            if (wr && a == 16'h4004) m_cmp[63:32] <= tb_merge(m_cmp[63:32], BUS_WDATA, BUS_WSTRB);
            if (wr && a == 16'h0000 && BUS_WSTRB[0]) begin
                m_msip <= BUS_WDATA[0];
                m_sw   <= BUS_WDATA[0] && !m_msip;
            end else begin
                m_sw   <= 1'b0;
            end
        end
    end

    // ---------------- bus driver (drive + capture only) ----------------
    logic [31:0] exp_rd [2];
    logic        exp_er;
    logic [31:0] cap_rd  [2];
    logic        cap_rdy [2];
    logic        cap_err [2];

    task automatic bus(input logic we, input logic [15:0] addr, input logic [3:0] strb, input logic [31:0] data);
        BUS_EN = 1'b1; BUS_WE = we; BUS_ADDR = addr; BUS_WSTRB = strb; BUS_WDATA = data;
        exp_er = !tb_mapped(addr);
        for (int i = 0; i < 2; i++) exp_rd[i] = (we || exp_er) ? 32'd0 : tb_read(i, addr);
        @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            cap_rd[i] = rdata[i]; cap_rdy[i] = ready[i]; cap_err[i] = err[i];
        end
        BUS_EN = 1'b0; BUS_WE = 1'b0; BUS_WSTRB = 4'h0;
    endtask

    task automatic do_reset();
        RST_N = 1'b0; DEBUG_HALT = 1'b0;
        BUS_EN = 1'b1; BUS_WE = 1'b0; BUS_ADDR = 16'hBFF8;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1; BUS_EN = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST_N = 1'b0; BUS_EN = 1'b1; BUS_WE = 1'b0; BUS_ADDR = 16'h4000;
        repeat (2) @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (ready[i] !== 1'b0 || rdata[i] !== 32'd0 || err[i] !== 1'b0)
                $display("FAIL reset_bus[%0d]: ready=%b rdata=%h err=%b want 0/0/0", i, ready[i], rdata[i], err[i]); else n_pass++;
            n_checks++; if (expired[i] !== 1'b0 || swi[i] !== 1'b0 || msip_o[i] !== 1'b0 || mtime[i] !== 64'd0)
                $display("FAIL reset_state[%0d]: exp=%b swi=%b msip=%b mtime=%h want all 0", i, expired[i], swi[i], msip_o[i], mtime[i]); else n_pass++;
        end
        RST_N = 1'b1; BUS_EN = 1'b0;
        bus(1'b0, 16'h4000, 4'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (cap_rdy[i] !== 1'b1 || cap_err[i] !== 1'b0 || cap_rd[i] !== 32'hFFFF_FFFF)
                $display("FAIL reset_cmp_lo[%0d]: ready=%b err=%b rdata=%h want 1/0/ffffffff", i, cap_rdy[i], cap_err[i], cap_rd[i]); else n_pass++;
        end
        bus(1'b0, 16'h4004, 4'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (cap_rdy[i] !== 1'b1 || cap_rd[i] !== 32'hFFFF_FFFF)
                $display("FAIL reset_cmp_hi[%0d]: ready=%b rdata=%h want 1/ffffffff", i, cap_rdy[i], cap_rd[i]); else n_pass++;
        end
        @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (ready[i] !== 1'b0 || rdata[i] !== 32'd0 || expired[i] !== 1'b0)
                $display("FAIL ready_one_cycle[%0d]: ready=%b rdata=%h exp=%b want 0/0/0", i, ready[i], rdata[i], expired[i]); else n_pass++;
        end
    endtask

    task automatic test_prescale();
        do_reset();
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            for (int i = 0; i < 2; i++) begin
                n_checks++; if (mtime[i] !== m_time[i])
                    $display("FAIL prescale_mtime[%0d] c%0d: got %h want %h", i, c, mtime[i], m_time[i]); else n_pass++;
            end
        end
        bus(1'b0, 16'hBFF8, 4'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (cap_rd[i] !== exp_rd[i])
                $display("FAIL prescale_read[%0d]: got %h want %h", i, cap_rd[i], exp_rd[i]); else n_pass++;
        end
        n_checks++; if (cap_rd[0] < 32'd9 || cap_rd[0] > 32'd11)
            $display("FAIL prescale_div4: got %h want 0000000a +-1", cap_rd[0]); else n_pass++;
    endtask

    task automatic test_carry();
        bus(1'b1, 16'hBFF8, 4'hF, 32'hFFFF_FFFE);
        bus(1'b1, 16'hBFFC, 4'hF, 32'h0000_0000);
        repeat (9) @(negedge CLK);
        bus(1'b0, 16'hBFFC, 4'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (cap_rd[i] !== exp_rd[i] || cap_rd[i] !== 32'h0000_0001)
                $display("FAIL carry_hi[%0d]: got %h want %h (00000001)", i, cap_rd[i], exp_rd[i]); else n_pass++;
        end
        bus(1'b0, 16'hBFF8, 4'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (cap_rd[i] !== exp_rd[i])
                $display("FAIL carry_lo[%0d]: got %h want %h", i, cap_rd[i], exp_rd[i]); else n_pass++;
        end
    endtask

    task automatic test_timer();
        bit          rose [2];
        logic [63:0] at_rise [2];
        bus(1'b1, 16'hBFFC, 4'hF, 32'd0);
        bus(1'b1, 16'hBFF8, 4'hF, 32'd0);
        bus(1'b1, 16'h4004, 4'hF, 32'd0);
        bus(1'b1, 16'h4000, 4'hF, 32'd20);
        rose[0] = 1'b0; rose[1] = 1'b0;
        for (int c = 0; c < 88; c++) begin
            @(negedge CLK);
            for (int i = 0; i < 2; i++) begin
                n_checks++; if (expired[i] !== m_exp[i])
                    $display("FAIL timer_level[%0d] c%0d: got %b want %b", i, c, expired[i], m_exp[i]); else n_pass++;
                if (expired[i] === 1'b1 && !rose[i]) begin
                    rose[i] = 1'b1; at_rise[i] = mtime[i];
                end
            end
        end
        n_checks++; if (!rose[0] || at_rise[0] !== 64'd20)
            $display("FAIL timer_rise_div4: rose=%0d mtime_at_rise=%0d want 1/20", rose[0], at_rise[0]); else n_pass++;
        n_checks++; if (!rose[1] || at_rise[1] !== 64'd21)
            $display("FAIL timer_rise_div1: rose=%0d mtime_at_rise=%0d want 1/21", rose[1], at_rise[1]); else n_pass++;
        bus(1'b1, 16'h4000, 4'hF, 32'd100);
        n_checks++; if (expired[0] !== 1'b1)
            $display("FAIL timer_hold: got %b want 1", expired[0]); else n_pass++;
        @(negedge CLK);
        n_checks++; if (expired[0] !== 1'b0)
            $display("FAIL timer_drop: got %b want 0", expired[0]); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (expired[i] !== m_exp[i])
                $display("FAIL timer_after_raise[%0d]: got %b want %b", i, expired[i], m_exp[i]); else n_pass++;
        end
    endtask

    task automatic test_msip();
        logic [3:0]  strb_v [5] = '{4'h1, 4'h1, 4'hF, 4'hE, 4'hF};
        logic [31:0] data_v [5] = '{32'h1, 32'h1, 32'h0, 32'h1, 32'hFFFF_FFFF};
        logic        msip_v [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        pulse_v[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 5; k++) begin
            bus(1'b1, 16'h0000, strb_v[k], data_v[k]);
            for (int i = 0; i < 2; i++) begin
                n_checks++; if (msip_o[i] !== msip_v[k] || swi[i] !== pulse_v[k] || swi[i] !== m_sw)
                    $display("FAIL msip_step%0d[%0d]: msip=%b swi=%b want %b/%b", k, i, msip_o[i], swi[i], msip_v[k], pulse_v[k]); else n_pass++;
            end
            @(negedge CLK);
            for (int i = 0; i < 2; i++) begin
                n_checks++; if (swi[i] !== 1'b0)
                    $display("FAIL msip_pulse_width%0d[%0d]: swi=%b want 0", k, i, swi[i]); else n_pass++;
            end
        end
        bus(1'b0, 16'h0000, 4'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (cap_rd[i] !== 32'h0000_0001)
                $display("FAIL msip_read[%0d]: got %h want 00000001", i, cap_rd[i]); else n_pass++;
        end
        bus(1'b1, 16'h0000, 4'h1, 32'h0);
    endtask

    task automatic test_halt();
        logic [63:0] t0 [2];
        for (int i = 0; i < 2; i++) t0[i] = mtime[i];
        DEBUG_HALT = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (c == 20) begin
                bus(1'b0, 16'h1234, 4'h0, 32'h0);
                for (int i = 0; i < 2; i++) begin
                    n_checks++; if (cap_rdy[i] !== 1'b1 || cap_err[i] !== 1'b1 || cap_rd[i] !== 32'd0)
                        $display("FAIL unmapped_read[%0d]: ready=%b err=%b rdata=%h want 1/1/0", i, cap_rdy[i], cap_err[i], cap_rd[i]); else n_pass++;
                end
            end else if (c == 30) begin
                bus(1'b1, 16'h2000, 4'hF, $urandom);
                for (int i = 0; i < 2; i++) begin
                    n_checks++; if (cap_rdy[i] !== 1'b1 || cap_err[i] !== 1'b1)
                        $display("FAIL unmapped_write[%0d]: ready=%b err=%b want 1/1", i, cap_rdy[i], cap_err[i]); else n_pass++;
                end
            end else begin
                @(negedge CLK);
            end
            for (int i = 0; i < 2; i++) begin
                n_checks++; if (mtime[i] !== t0[i])
                    $display("FAIL halt_hold[%0d] c%0d: got %h want %h", i, c, mtime[i], t0[i]); else n_pass++;
            end
        end
        DEBUG_HALT = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            for (int i = 0; i < 2; i++) begin
                n_checks++; if (mtime[i] !== m_time[i])
                    $display("FAIL halt_resume[%0d] c%0d: got %h want %h", i, c, mtime[i], m_time[i]); else n_pass++;
            end
        end
    endtask

    task automatic test_tick_collision();
        logic [63:0] prev [2];
        logic [31:0] d;
        logic [3:0]  s;
        for (int k = 0; k < 6; k++) begin
            d = $urandom;
            s = (k == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            for (int i = 0; i < 2; i++) prev[i] = mtime[i];
            bus(1'b1, 16'hBFF8, s, d);
            for (int i = 0; i < 2; i++) begin
                n_checks++; if (mtime[i] !== {prev[i][63:32], tb_merge(prev[i][31:0], d, s)} || mtime[i] !== m_time[i])
                    $display("FAIL tick_collision%0d[%0d]: got %h want %h", k, i, mtime[i], {prev[i][63:32], tb_merge(prev[i][31:0], d, s)}); else n_pass++;
            end
        end
    endtask

    task automatic test_wrap();
        bus(1'b1, 16'hBFFC, 4'hF, 32'hFFFF_FFFF);
        bus(1'b1, 16'hBFF8, 4'hF, 32'hFFFF_FFFD);
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            for (int i = 0; i < 2; i++) begin
                n_checks++; if (mtime[i] !== m_time[i] || expired[i] !== m_exp[i])
                    $display("FAIL wrap[%0d] c%0d: mtime=%h exp=%b want %h/%b", i, c, mtime[i], expired[i], m_time[i], m_exp[i]); else n_pass++;
            end
        end
        n_checks++; if (mtime[1] !== 64'd5)
            $display("FAIL wrap_div1: got %h want 5", mtime[1]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] bases [6] = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h0000};
        logic [15:0] a;
        logic        we;
        for (int k = 0; k < 24; k++) begin
            int sel;
            sel = $urandom_range(0, 5);
            a = bases[sel] | 16'($urandom_range(0, 3));
            if (sel == 5) begin
                a = 16'($urandom);
                if (tb_mapped(a)) a = a ^ 16'h0100;
            end
            we = 1'($urandom_range(0, 1));
            bus(we, a, 4'($urandom), $urandom);
            for (int i = 0; i < 2; i++) begin
                n_checks++; if (cap_rdy[i] !== 1'b1 || cap_err[i] !== exp_er || cap_rd[i] !== exp_rd[i])
                    $display("FAIL b2b%0d[%0d] we=%b addr=%h: ready=%b err=%b rdata=%h want 1/%b/%h", k, i, we, a, cap_rdy[i], cap_err[i], cap_rd[i], exp_er, exp_rd[i]); else n_pass++;
            end
        end
        @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (ready[i] !== 1'b0 || mtime[i] !== m_time[i] || expired[i] !== m_exp[i] || msip_o[i] !== m_msip)
                $display("FAIL b2b_end[%0d]: ready=%b mtime=%h exp=%b msip=%b want 0/%h/%b/%b", i, ready[i], mtime[i], expired[i], msip_o[i], m_time[i], m_exp[i], m_msip); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        bus(1'b1, 16'h0000, 4'h1, 32'h1);
        BUS_EN = 1'b1; BUS_WE = 1'b0; BUS_ADDR = 16'h4000; RST_N = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (ready[i] !== 1'b0 || rdata[i] !== 32'd0 || msip_o[i] !== 1'b0 || mtime[i] !== 64'd0 || expired[i] !== 1'b0 || swi[i] !== 1'b0)
                $display("FAIL reset_mid[%0d]: ready=%b rdata=%h msip=%b mtime=%h exp=%b swi=%b want all 0", i, ready[i], rdata[i], msip_o[i], mtime[i], expired[i], swi[i]); else n_pass++;
        end
        RST_N = 1'b1; BUS_EN = 1'b0;
        bus(1'b0, 16'h4004, 4'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (cap_rd[i] !== 32'hFFFF_FFFF)
                $display("FAIL reset_mid_cmp[%0d]: got %h want ffffffff", i, cap_rd[i]); else n_pass++;
        end
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_prescale();
        test_carry();
        test_timer();
        test_msip();
        test_halt();
        test_tick_collision();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/peak_rv32i_clint.md
Name: peak_rv32i_clint

Overview:
- Core-local interruptor for the single-hart RV32 core; memory-mapped on the data bus.
- Holds the 64-bit mtime counter, the 64-bit mtimecmp compare register and the msip bit.
- Directly upstream of the CSR block: drives its TIMER_EXPIRED level and its SW_INTERRUPT pulse.
- Freezes mtime while the core is halted in debug mode.

Parameters:
- TICK_DIV, 1, CLK cycles per mtime increment (1..65535); 1 means increment every cycle.
- BASE_ADDR, 16'h0000, bus address of the register window (64 KiB aligned window, bits [15:0] decoded).

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset; synchronous, active-low
- BUS_EN  in  1  bus request strobe, one cycle per access
- BUS_WE  in  1  1=write, 0=read
- BUS_ADDR  in  16  byte address, bits [1:0] ignored
- BUS_WSTRB  in  4  byte write enables
- BUS_WDATA  in  32  write data
- BUS_RDATA  out  32  read data, valid with BUS_READY
- BUS_READY  out  1  access complete
- BUS_ERR  out  1  unmapped address, valid with BUS_READY
- DEBUG_HALT  in  1  core halted; mtime stops counting
- TIMER_EXPIRED  out  1  level: mtime >= mtimecmp
- SW_INTERRUPT  out  1  one-cycle pulse when msip goes 0->1
- MSIP  out  1  current msip level
- MTIME  out  64  current mtime (for the time/timeh CSR shadow)

Behaviour:

Register map (offset from BASE_ADDR):
- 0x0000 msip: bit0 only; other bits read 0.
- 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32].
- 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
- Any other offset is unmapped.

Reset values:
- mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, msip = 0, prescaler = 0.
- BUS_RDATA = 0, BUS_READY = 0, BUS_ERR = 0, SW_INTERRUPT = 0, TIMER_EXPIRED = 0.

Bus handshake:
- BUS_EN sampled at posedge.
- BUS_READY is asserted exactly the next cycle, for one cycle, for both reads and writes; there are no wait states.
- A new BUS_EN may arrive in the same cycle that BUS_READY is high, giving back-to-back throughput of 1 access/cycle.
- Read: BUS_RDATA is registered from the register value at the BUS_EN edge. It is 0 when no read completes and 0 for unmapped addresses.
- Write: byte lanes are applied per BUS_WSTRB at the BUS_EN edge, so the new value is visible the next cycle. WSTRB = 0 is a legal no-op.
- Unmapped access: writes are dropped; BUS_READY and BUS_ERR are both asserted the next cycle.

Prescaler and counting:
- A counter counts 0..TICK_DIV-1, then emits a tick and wraps to 0.
- When TICK_DIV = 1, a tick is emitted every cycle.
- On each tick, mtime increments by 1 as a full 64-bit add, so carry propagates into the high word. It wraps FFFF_FFFF_FFFF_FFFF -> 0.
- While DEBUG_HALT=1, the prescaler and mtime both hold. Counting resumes on the first cycle after deassertion, and the prescaler is not reset.

Simultaneous events:
- A bus write to either mtime half in the same cycle as a tick: the written bytes take the write data; unwritten bytes of that half keep their pre-increment value; the other half keeps its current value. The tick is lost; there is no carry into or out of the written half that cycle.
- A bus write to mtimecmp does not affect counting.

TIMER_EXPIRED:
- Registered unsigned 64-bit compare of mtime >= mtimecmp, using the post-update values. It is therefore 1 cycle after the register change.
- It stays high until mtimecmp is raised above mtime or mtime wraps.
- It is a level; the block has no latched state for it.

msip and SW_INTERRUPT:
- msip is written via the bus, bit0 of lane 0.
- SW_INTERRUPT is high for exactly one cycle, the cycle after msip changes 0->1.
- Writing 1 while msip is already 1 produces no pulse.
- Clearing msip produces no pulse.

Reset mid-operation:
- RST_N low during an access: the access is abandoned, BUS_READY is not asserted, and all registers return to their reset values on that edge.

Decomposition:
- Package peak_clint_pkg holds:
  - offset constants CLINT_MSIP, CLINT_MTIMECMP_LO/HI, CLINT_MTIME_LO/HI;
  - a byte-merge function (old, wdata, wstrb) -> new.
- Sub-module peak_clint_tick_gen: prescaler with TICK_DIV, an enable (= !DEBUG_HALT) and a TICK output.
- The top module holds the registers, the decode, the bus response and the compare.

Test Plan:
- Reset, then read 0x4000/0x4004 -> FFFF_FFFF, FFFF_FFFF; TIMER_EXPIRED=0; BUS_READY one cycle after each BUS_EN.
- TICK_DIV=4: after reset, wait 40 cycles and read 0xBFF8 -> 0000_000A (±1 for read-edge alignment, checked against a model).
- Write mtime = 0000_0000_FFFF_FFFE (lo then hi), TICK_DIV=1: after 2 ticks read hi -> 0000_0001 and lo -> 0000_0000 (carry check).
- Write mtimecmp = 20, mtime = 0: TIMER_EXPIRED rises on the cycle after mtime reaches 20. Then write mtimecmp_lo = 100 -> it drops 1 cycle later.
- Write 1 to 0x0000: SW_INTERRUPT is high exactly 1 cycle and MSIP=1. Writing 1 again gives no pulse. Writing 0 gives MSIP=0 and no pulse.
- DEBUG_HALT high for 50 cycles: mtime is unchanged across the window. Read of 0x1234 -> RDATA 0, BUS_ERR=1. A write to mtime_lo coincident with a tick takes the written value and loses the tick.
